// File: rtl/sme_wild_pkg.sv
// Shared constants, FSM state type and width helper for the sme_wild string matcher.
package sme_pkg;

    localparam logic [7:0] CH_BEGIN = 8'h5E;
    localparam logic [7:0] CH_END   = 8'h24;
    localparam logic [7:0] CH_ANY   = 8'h2E;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_S,
        ST_LOAD_P,
        ST_SEARCH,
        ST_SUFFIX,
        ST_DONE
    } state_e;

    function automatic int calc_iw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sme_wild_if.sv
// Character-stream load/result interface of the sme_wild matcher.
interface sme_wild_if #(
    parameter int DW = 8,
    parameter int IW = 5
) ();

    logic [DW-1:0] chardata;
    logic          isstring;
    logic          ispattern;
    logic          valid;
    logic          match;
    logic [IW-1:0] match_index;
    logic          busy;

    modport master (
        output chardata, isstring, ispattern,
        input  valid, match, match_index, busy
    );

    modport slave (
        input  chardata, isstring, ispattern,
        output valid, match, match_index, busy
    );

endinterface

// File: rtl/sme_wild_char_cmp.sv
// Per-slot compare of one pattern character against one string slot.
module sme_char_cmp
    import sme_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] pat_ch,
    input  logic [DW-1:0] str_ch,
    input  logic          is_bnd,
    output logic          eq
);

    always_comb begin
        eq = 1'b0;
        if (pat_ch == DW'(CH_BEGIN) || pat_ch == DW'(CH_END)) begin
            eq = is_bnd || (str_ch == DW'(CH_SPACE));
        end else if (pat_ch == DW'(CH_ANY)) begin
            eq = !is_bnd;
        end else begin
            eq = !is_bnd && (str_ch == pat_ch);
        end
    end

endmodule

// File: rtl/sme_wild.sv
// String matcher with ^ $ . metacharacters and one '*' wildcard per pattern.
module sme_wild
    import sme_pkg::*;
#(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int DW      = 8,
    parameter int IW      = calc_iw(STR_MAX)
) (
    input  logic      clk,
    input  logic      reset,
    sme_wild_if.slave bus
);

    localparam int SIW = calc_iw(STR_MAX);
    localparam int PIW = calc_iw(PAT_MAX);
    localparam int SLW = $clog2(STR_MAX + 1);
    localparam int PLW = $clog2(PAT_MAX + 1);
    localparam int PW  = $clog2(STR_MAX + PAT_MAX + 2) + 1;

    localparam logic signed [PW-1:0] S_NEG1 = '1;
    localparam logic signed [PW-1:0] S_ZERO = '0;
    localparam logic signed [PW-1:0] S_ONE  = PW'(1);

    state_e               state_q, state_d;
    logic [DW-1:0]        str_q [STR_MAX];
    logic [DW-1:0]        str_d [STR_MAX];
    logic [DW-1:0]        pat_q [PAT_MAX];
    logic [DW-1:0]        pat_d [PAT_MAX];
    logic [SLW-1:0]       str_len_q, str_len_d;
    logic [PLW-1:0]       pat_len_q, pat_len_d;
    logic [PLW-1:0]       star_pos_q, star_pos_d;
    logic [PLW-1:0]       k_q, k_d;
    logic                 star_q, star_d;
    logic signed [PW-1:0] s_q, s_d, t_q, t_d;
    logic                 match_q, match_d;
    logic [IW-1:0]        idx_q, idx_d;

    logic [PLW-1:0]       p1_len, p2_len, seg_len, seg_off, pidx;
    logic signed [PW-1:0] len_s, base, pos, res_s;
    logic [IW-1:0]        res_idx;
    logic [DW-1:0]        cmp_pat, cmp_str;
    logic                 at_lo, at_hi, in_rng, is_bnd, cmp_eq, hit;
    logic                 seg_done, last_start;

    // SEARCH walks prefix P1 from start s; SUFFIX walks P2 from t. Both share one comparator.
    always_comb begin
        p1_len  = star_q ? star_pos_q : pat_len_q;
        p2_len  = star_q ? (pat_len_q - star_pos_q - PLW'(1)) : '0;
        seg_len = (state_q == ST_SUFFIX) ? p2_len : p1_len;
        seg_off = (state_q == ST_SUFFIX) ? (p1_len + PLW'(1)) : '0;
        base    = (state_q == ST_SUFFIX) ? t_q : s_q;
        len_s   = signed'(PW'(str_len_q));
        pos     = base + signed'(PW'(k_q));
        pidx    = seg_off + k_q;
        cmp_pat = (pidx < PLW'(PAT_MAX)) ? pat_q[pidx[PIW-1:0]] : '0;
        at_lo   = (pos == S_NEG1);
        at_hi   = (pos == len_s);
        in_rng  = (pos >= S_NEG1) && (pos <= len_s);
        // '^' only sees the leading boundary and '$' only the trailing one
        is_bnd  = (at_lo && cmp_pat != DW'(CH_END)) || (at_hi && cmp_pat != DW'(CH_BEGIN));
        cmp_str = (in_rng && !at_lo && !at_hi) ? str_q[pos[SIW-1:0]] : '0;
        hit        = in_rng && cmp_eq;
        seg_done   = (k_q >= seg_len);
        last_start = (base >= len_s);

        if (pat_q[0] == DW'(CH_BEGIN)) begin
            res_s = s_q + S_ONE;
        end else if (s_q < S_ZERO) begin
            res_s = S_ZERO;
        end else begin
            res_s = s_q;
        end
        res_idx = IW'(unsigned'(res_s));
    end

    sme_char_cmp #(.DW(DW)) u_cmp (
        .pat_ch (cmp_pat),
        .str_ch (cmp_str),
        .is_bnd (is_bnd),
        .eq     (cmp_eq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            str_len_q  <= '0;
            pat_len_q  <= '0;
            star_pos_q <= '0;
            star_q     <= 1'b0;
            k_q        <= '0;
            s_q        <= '0;
            t_q        <= '0;
            match_q    <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            str_len_q  <= str_len_d;
            pat_len_q  <= pat_len_d;
            star_pos_q <= star_pos_d;
            star_q     <= star_d;
            k_q        <= k_d;
            s_q        <= s_d;
            t_q        <= t_d;
            match_q    <= match_d;
            idx_q      <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        str_q <= str_d;
        pat_q <= pat_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.isstring)       state_d = ST_LOAD_S;
                else if (bus.ispattern) state_d = ST_LOAD_P;
                else                    state_d = ST_IDLE;
            end
            ST_LOAD_S: begin
                if (bus.isstring)       state_d = ST_LOAD_S;
                else if (bus.ispattern) state_d = ST_LOAD_P;
                else                    state_d = ST_IDLE;
            end
            ST_LOAD_P: begin
                if (!bus.ispattern) state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (seg_done)                 state_d = star_q ? ST_SUFFIX : ST_DONE;
                else if (!hit && last_start) state_d = ST_DONE;
            end
            ST_SUFFIX: begin
                if (seg_done || (!hit && last_start)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        str_d      = str_q;
        str_len_d  = str_len_q;
        pat_d      = pat_q;
        pat_len_d  = pat_len_q;
        star_d     = star_q;
        star_pos_d = star_pos_q;
        s_d        = s_q;
        t_d        = t_q;
        k_d        = k_q;
        match_d    = match_q;
        idx_d      = idx_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_LOAD_S: begin
                if (bus.isstring) begin
                    if (state_q != ST_LOAD_S) begin
                        str_d[0]  = bus.chardata;
                        str_len_d = SLW'(1);
                    end else if (str_len_q < SLW'(STR_MAX)) begin
                        str_d[str_len_q[SIW-1:0]] = bus.chardata;
                        str_len_d = str_len_q + SLW'(1);
                    end
                end else if (bus.ispattern) begin
                    pat_d[0]   = bus.chardata;
                    pat_len_d  = PLW'(1);
                    star_d     = (bus.chardata == DW'(CH_STAR));
                    star_pos_d = '0;
                end
            end
            ST_LOAD_P: begin
                if (bus.ispattern) begin
                    if (pat_len_q < PLW'(PAT_MAX)) begin
                        pat_d[pat_len_q[PIW-1:0]] = bus.chardata;
                        pat_len_d = pat_len_q + PLW'(1);
                        if (!star_q && bus.chardata == DW'(CH_STAR)) begin
                            star_d     = 1'b1;
                            star_pos_d = pat_len_q;
                        end
                    end
                end else begin
                    s_d = S_NEG1;
                    k_d = '0;
                end
            end
            ST_SEARCH: begin
                if (seg_done) begin
                    if (star_q) begin
                        t_d = s_q + signed'(PW'(p1_len));
                        k_d = '0;
                    end else begin
                        match_d = 1'b1;
                        idx_d   = res_idx;
                    end
                end else if (hit) begin
                    k_d = k_q + PLW'(1);
                end else if (last_start) begin
                    match_d = 1'b0;
                    idx_d   = '0;
                end else begin
                    s_d = s_q + S_ONE;
                    k_d = '0;
                end
            end
            ST_SUFFIX: begin
                if (seg_done) begin
                    match_d = 1'b1;
                    idx_d   = res_idx;
                end else if (hit) begin
                    k_d = k_q + PLW'(1);
                end else if (last_start) begin
                    match_d = 1'b0;
                    idx_d   = '0;
                end else begin
                    t_d = t_q + S_ONE;
                    k_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.valid       = (state_q == ST_DONE);
        bus.busy        = (state_q == ST_SEARCH) || (state_q == ST_SUFFIX);
        bus.match       = match_q;
        bus.match_index = idx_q;
    end

endmodule

// File: tb/tb_sme_wild.sv
// Scoreboard bench for sme_wild: expected results queued at pattern load, checked on valid.
module tb_sme_wild;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int DW      = 8;
    localparam int IW      = 5;
    localparam int BUDGET  = (STR_MAX + 2) * (PAT_MAX + 1) + 4 + 2;

    typedef struct {
        logic          m;
        logic [IW-1:0] idx;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic clk    = 1'b0;
    logic reset;

    sme_wild_if #(.DW(DW), .IW(IW)) bus ();

    sme_wild #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .DW(DW), .IW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
        bus.chardata  = '0;
    endtask

    task automatic send_string(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus.isstring  = 1'b1;
            bus.ispattern = 1'b0;
            bus.chardata  = DW'(s[i]);
        end
    endtask

    task automatic send_pattern(input string p);
        for (int i = 0; i < p.len(); i++) begin
            @(negedge clk);
            bus.isstring  = 1'b0;
            bus.ispattern = 1'b1;
            bus.chardata  = DW'(p[i]);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic wait_valid(output logic got, output logic m, output logic [IW-1:0] idx);
        got = 1'b0;
        m   = 1'b0;
        idx = '0;
        for (int c = 0; c < BUDGET && !got; c++) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) begin
                got = 1'b1;
                m   = bus.match;
                idx = bus.match_index;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL reset_match: got %b want 0", bus.match); end
        checks++; if (bus.match_index !== '0) begin errors++; $display("FAIL reset_index: got %0d want 0", bus.match_index); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        logic got, m;
        logic [IW-1:0] idx;
        e.m = 1'b1; e.idx = IW'(6); e.name = "^wor";
        sb.push_back(e);
        send_string("hello world");
        send_pattern("^wor");
        wait_valid(got, m, idx);
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s: no valid within %0d cycles", e.name, BUDGET);
        end else begin
            checks++; if (m !== e.m) begin errors++; $display("FAIL %s match: got %b want %b", e.name, m, e.m); end
            checks++; if (idx !== e.idx) begin errors++; $display("FAIL %s index: got %0d want %0d", e.name, idx, e.idx); end
            @(posedge clk);
            #1;
            checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: got %b want 0", bus.valid); end
        end
    endtask

    // Patterns against the currently stored string, issued back to back.
    task automatic test_patterns(input string tag, input string pats[4], input logic ms[4],
                                 input logic [IW-1:0] idxs[4], input int n);
        exp_t e;
        logic got, m;
        logic [IW-1:0] idx;
        for (int i = 0; i < n; i++) begin
            e.m = ms[i]; e.idx = idxs[i]; e.name = {tag, ":", pats[i]};
            sb.push_back(e);
            send_pattern(pats[i]);
            wait_valid(got, m, idx);
            e = sb.pop_front();
            checks++;
            if (!got) begin
                errors++; $display("FAIL %s: no valid within %0d cycles", e.name, BUDGET);
            end else begin
                checks++; if (m !== e.m) begin errors++; $display("FAIL %s match: got %b want %b", e.name, m, e.m); end
                checks++; if (idx !== e.idx) begin errors++; $display("FAIL %s index: got %0d want %0d", e.name, idx, e.idx); end
            end
        end
    endtask

    task automatic test_reuse();
        test_patterns("reuse", '{"o.w", "d$", "", ""}, '{1'b1, 1'b1, 1'b0, 1'b0},
                      '{IW'(4), IW'(10), IW'(0), IW'(0)}, 2);
    endtask

    task automatic test_wildcard();
        test_patterns("wild", '{"h*d$", "w*z", "", ""}, '{1'b1, 1'b0, 1'b0, 1'b0},
                      '{IW'(0), IW'(0), IW'(0), IW'(0)}, 2);
    endtask

    task automatic test_pattern_overflow();
        test_patterns("patovf", '{"hello wozzz", "", "", ""}, '{1'b1, 1'b0, 1'b0, 1'b0},
                      '{IW'(0), IW'(0), IW'(0), IW'(0)}, 1);
    endtask

    task automatic test_full_string();
        send_string("abcdefghijklmnopqrstuvwxABCDEFGH");
        test_patterns("full", '{"ABCDEFGH", "H$", "", ""}, '{1'b1, 1'b1, 1'b0, 1'b0},
                      '{IW'(24), IW'(31), IW'(0), IW'(0)}, 2);
    endtask

    task automatic test_string_overflow();
        send_string("QabcdefghijklmnopqrstuvwxyzabcdeXY");
        test_patterns("strovf", '{"^Q", "e$", "XY", ""}, '{1'b1, 1'b1, 1'b0, 1'b0},
                      '{IW'(0), IW'(31), IW'(0), IW'(0)}, 3);
    endtask

    task automatic test_reset_abort();
        logic saw;
        send_string("hello world");
        send_pattern("xyz");
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_cycle%0d: got %b want 1", c, bus.busy); end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", bus.valid); end
        checks++; if (bus.match !== 1'b0 || bus.match_index !== '0) begin
            errors++; $display("FAIL abort_outputs: got match=%b index=%0d want 0/0", bus.match, bus.match_index);
        end
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (BUDGET) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got %b want 0", saw); end
    endtask

    task automatic test_empty_string();
        test_patterns("empty", '{"*", "^$", "a", "$"}, '{1'b1, 1'b1, 1'b0, 1'b1},
                      '{IW'(0), IW'(0), IW'(0), IW'(0)}, 4);
    endtask

    task automatic test_back_to_back();
        send_string("hello world");
        test_patterns("b2b", '{"d$", "^wor", "l*o", "o.w"}, '{1'b1, 1'b1, 1'b1, 1'b1},
                      '{IW'(10), IW'(6), IW'(2), IW'(4)}, 4);
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_basic();
        test_reuse();
        test_wildcard();
        test_pattern_overflow();
        test_full_string();
        test_string_overflow();
        test_reset_abort();
        test_empty_string();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
